// File: rtl/maze_probe_if.sv
// maze_probe_if
// Tile ROM read bus between the maze probe (master) and the synchronous
// tile ROM (slave).
//   rom_addr : tile address, driven by the master
//   rom_rd   : read strobe, high while an address is being presented
//   rom_data : tile code, returned by the ROM one cycle after the address
interface maze_probe_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd;
    logic [4:0]        rom_data;

    modport master (output rom_addr, output rom_rd, input rom_data);
    modport slave  (input rom_addr, input rom_rd, output rom_data);
endinterface

// File: rtl/maze_probe.sv
// maze_probe
// On each frame tick, snapshots the sprite position and reads the tile ROM
// at the four probe pixels just outside the sprite (left, right, below,
// above).  All four wall codes are then published together, so the movement
// block never sees a mix of old and new codes.
// Ports:
//   Clk, Reset_n         : system clock, synchronous active-low reset
//   frame_clk            : raw frame tick, synchronised here
//   BallX, BallY, BallS  : sprite centre and half-size in pixels
//   rom                  : tile ROM bus (master side)
//   mapL/mapR/mapB/mapT  : registered tile codes, 0 = open
//   probe_done           : one-cycle pulse when the map outputs update
//   busy                 : high while a probe sequence is in flight
module maze_probe #(
    parameter int TILE_SHIFT = 4,
    parameter int MAP_COLS   = 26,
    parameter int MAP_ROWS   = 28,
    parameter int ADDR_W     = 10
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                frame_clk,
    input  logic [9:0]          BallX,
    input  logic [9:0]          BallY,
    input  logic [9:0]          BallS,
    maze_probe_if.master        rom,
    output logic [4:0]          mapL,
    output logic [4:0]          mapR,
    output logic [4:0]          mapB,
    output logic [4:0]          mapT,
    output logic                probe_done,
    output logic                busy
);

    typedef enum logic [2:0] {IDLE, SNAP, RD_L, RD_R, RD_B, RD_T, CAP_T, DONE} state_t;

    // A probe outside the grid reads nothing and reports open; wrap and
    // clamping are the movement block's business.
    function automatic logic probe_oob(input logic signed [10:0] px,
                                       input logic signed [10:0] py);
        logic signed [10:0] col;
        logic signed [10:0] row;
        col = px >>> TILE_SHIFT;
        row = py >>> TILE_SHIFT;
        return (px < 0) || (py < 0) ||
               (int'(col) >= MAP_COLS) || (int'(row) >= MAP_ROWS);
    endfunction

    function automatic logic [ADDR_W-1:0] probe_addr(input logic signed [10:0] px,
                                                     input logic signed [10:0] py);
        int col;
        int row;
        int lin;
        col = int'(px >>> TILE_SHIFT);
        row = int'(py >>> TILE_SHIFT);
        lin = row * MAP_COLS + col;
        if (probe_oob(px, py))
            return '0;
        return lin[ADDR_W-1:0];
    endfunction

    state_t              state;
    logic [2:0]          sync;
    logic                frame_edge;
    logic                pending;

    logic signed [10:0]  ball_x;
    logic signed [10:0]  ball_y;
    logic signed [10:0]  reach;
    logic signed [10:0]  px_l, px_r, py_b, py_t;
    logic [ADDR_W-1:0]   addr_l;

    logic [ADDR_W-1:0]   addr_q [4];
    logic [3:0]          oob_q;
    logic [4:0]          shadow_l, shadow_r, shadow_b;

    // sync[1] is the second synchroniser flop, sync[2] the edge-detect flop.
    assign frame_edge = sync[1] & ~sync[2];

    // Probe pixels sit one pixel beyond the sprite edge; 11-bit signed so a
    // probe left of / above the screen goes negative.
    assign ball_x = signed'({1'b0, BallX});
    assign ball_y = signed'({1'b0, BallY});
    assign reach  = signed'({1'b0, BallS}) + 11'sd1;
    assign px_l   = ball_x - reach;
    assign px_r   = ball_x + reach;
    assign py_b   = ball_y + reach;
    assign py_t   = ball_y - reach;
    assign addr_l = probe_addr(px_l, ball_y);

    // Snapshot / shadow datapath: no reset, contents are only ever consumed
    // by a sequence that refilled them.
    always_ff @(posedge Clk) begin
        case (state)
            SNAP: begin
                addr_q[0] <= addr_l;
                addr_q[1] <= probe_addr(px_r, ball_y);
                addr_q[2] <= probe_addr(ball_x, py_b);
                addr_q[3] <= probe_addr(ball_x, py_t);
                oob_q     <= {probe_oob(ball_x, py_t), probe_oob(ball_x, py_b),
                              probe_oob(px_r, ball_y), probe_oob(px_l, ball_y)};
            end
            // ROM is one cycle behind: each RD state captures the slot before it.
            RD_R:    shadow_l <= oob_q[0] ? 5'd0 : rom.rom_data;
            RD_B:    shadow_r <= oob_q[1] ? 5'd0 : rom.rom_data;
            RD_T:    shadow_b <= oob_q[2] ? 5'd0 : rom.rom_data;
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sync         <= '0;
            state        <= IDLE;
            pending      <= 1'b0;
            rom.rom_rd   <= 1'b0;
            rom.rom_addr <= '0;
            probe_done   <= 1'b0;
            busy         <= 1'b0;
            mapL         <= 5'h1F;
            mapR         <= 5'h1F;
            mapB         <= 5'h1F;
            mapT         <= 5'h1F;
        end else begin
            sync       <= {sync[1:0], frame_clk};
            probe_done <= 1'b0;
            // Only one edge can be queued behind a running sequence.
            if (frame_edge && state != IDLE)
                pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (frame_edge || pending) begin
                        state   <= SNAP;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                    end
                end
                SNAP: begin
                    rom.rom_addr <= addr_l;
                    rom.rom_rd   <= 1'b1;
                    state        <= RD_L;
                end
                RD_L: begin
                    rom.rom_addr <= addr_q[1];
                    state        <= RD_R;
                end
                RD_R: begin
                    rom.rom_addr <= addr_q[2];
                    state        <= RD_B;
                end
                RD_B: begin
                    rom.rom_addr <= addr_q[3];
                    state        <= RD_T;
                end
                RD_T: begin
                    rom.rom_addr <= '0;
                    rom.rom_rd   <= 1'b0;
                    state        <= CAP_T;
                end
                CAP_T: begin
                    // All four codes change on this one edge.
                    mapL       <= shadow_l;
                    mapR       <= shadow_r;
                    mapB       <= shadow_b;
                    mapT       <= oob_q[3] ? 5'd0 : rom.rom_data;
                    probe_done <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (pending || frame_edge) begin
                        state   <= SNAP;
                        pending <= pending & frame_edge;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/maze_probe.md
# maze_probe

Upstream neighbour of the Pac-Man movement block. It produces the four wall codes `mapL`, `mapR`, `mapB` and `mapT` that the movement block consumes. On every rising edge of `frame_clk` it snapshots the current sprite position and reads the maze tile ROM at the four probe pixels (left, right, below, above). It then publishes all four tile codes atomically, so the movement logic sees a consistent set before its next frame tick.

## Interface
Parameters:
- `TILE_SHIFT`, default 4: tile size is 2^TILE_SHIFT pixels, square.
- `MAP_COLS`, default 26: maze width in tiles.
- `MAP_ROWS`, default 28: maze height in tiles.
- `ADDR_W`, default 10: ROM address width; MAP_COLS*MAP_ROWS must be ≤ 2^ADDR_W.

Ports:
- `Clk`  in  1  system clock (50 MHz); all logic is on its rising edge.
- `Reset_n`  in  1  synchronous, active-low reset.
- `frame_clk`  in  1  frame tick (vsync domain); synchronised internally.
- `BallX`, `BallY`  in  10 each  sprite centre, in pixels.
- `BallS`  in  10  sprite half-size, in pixels.
- `rom_addr`  out  ADDR_W  tile ROM read address.
- `rom_rd`  out  1  read strobe, for the bench monitor and power gating.
- `rom_data`  in  5  tile code. The ROM is synchronous: data appears 1 cycle after the address. Code 0 means open.
- `mapL`, `mapR`, `mapB`, `mapT`  out  5 each  registered tile codes.
- `probe_done`  out  1  one-cycle pulse when the map outputs update.
- `busy`  out  1  high while a probe sequence is in flight.

## Operation
- `frame_clk` passes through a 2-flop synchroniser and a third flop. A rising edge is detected when sync2=1 and sync3=0.
- FSM states: IDLE → SNAP → RD_L → RD_R → RD_B → RD_T → CAP_T → DONE → IDLE.
- IDLE: stays until an edge is detected or `pending`=1.
- SNAP: latches BallX, BallY and BallS, then computes the four probe points as 11-bit signed values:
  - L = (X−S−1, Y)
  - R = (X+S+1, Y)
  - B = (X, Y+S+1)
  - T = (X, Y−S−1)
- Tile address per probe: col = px>>TILE_SHIFT, row = py>>TILE_SHIFT, addr = row*MAP_COLS+col, truncated to ADDR_W.
- Out-of-grid probe: px<0, py<0, col≥MAP_COLS or row≥MAP_ROWS.
  - `rom_addr` is driven to 0 for that slot and its `rom_data` is discarded.
  - The result for that slot is forced to 0 (open). Tunnel wrap and border clamping belong to the movement block.
- RD_x states: drive `rom_addr` and set `rom_rd`=1. The data returned for the previous slot is captured into a shadow register.
- CAP_T: captures the T slot, `rom_rd`=0. Then all four map outputs are loaded from the shadow registers on the same edge.
- DONE: `probe_done`=1 for exactly one cycle.
- `busy` is 1 in every state except IDLE.
- Edge arriving while `busy`=1: sets `pending`. At most one edge is queued; further edges are dropped. DONE clears `pending` and moves to SNAP instead of IDLE when `pending`=1.
- Map outputs never change except on the CAP_T→DONE edge. Partial results are never visible.

## Timing
- Reset (Reset_n=0 at a clock edge) gives:
  - state IDLE; `pending`, `rom_rd`, `probe_done` and `busy` = 0
  - `rom_addr` = 0
  - all map outputs = 5'h1F (blocked until the first probe completes)
  - synchroniser flops = 0
- Reset mid-sequence aborts immediately to the reset values. Shadow registers are discarded.
- Latency: edge detect in cycle T0 (IDLE) → SNAP T1 → RD_L..RD_T T2–T5 → CAP_T T6. Maps update on the edge ending T6, and `probe_done` is high in T7. That is 7 cycles from detect to update, plus 2–3 cycles of synchroniser delay from the raw `frame_clk` edge.
- `rom_addr` for slot k is valid in its RD cycle. `rom_data` is sampled on the edge ending the following cycle.
- A back-to-back pending sequence starts its SNAP in the cycle after DONE.

## Test plan
- **Reset:** hold Reset_n=0 for 3 cycles, release. All maps = 1F, `busy`=0, `probe_done`=0, and no `rom_rd` until a frame edge arrives.
- **Centre probe:** BallX=202, BallY=253, BallS=13. The ROM model returns addr[7:0] truncated to 5 bits. Required:
  - `rom_addr` sequence 401, 403, 428, 376
  - mapL=0x11, mapR=0x13, mapB=0x0C, mapT=0x18
  - `probe_done` exactly 7 cycles after edge detect
- **Atomicity:** change BallX to 300 during RD_R. The outputs still reflect the snapshot at 202, and the maps stay unchanged until the DONE cycle.
- **Tunnel / out-of-grid:** BallX=5, BallY=209, BallS=13, with the ROM returning 1F everywhere. Required: the left slot drives `rom_addr`=0 and mapL=0; the right slot reads addr 339 and mapR=1F.
- **Pending:** two frame edges 3 cycles apart, then a third while busy. Exactly two sequences run back-to-back, with two `probe_done` pulses 7 cycles apart; the third edge is dropped.
- **Reset mid-op:** assert Reset_n=0 in RD_B. The next cycle shows maps = 1F, `busy`=0, and no `probe_done`.
